// File: rtl/natalius_pkg.sv
// natalius_pkg
// Shared definitions for the Natalius I/O port arbiter: FSM state
// encoding, requester IDs and the I/O port width.
package natalius_pkg;

    localparam int PORT_W = 8;

    // Requester IDs; also the bit positions in the arbiter request/grant vectors.
    localparam logic REQ_CPU  = 1'b0;
    localparam logic REQ_MGMT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/natalius_rr_arb2.sv
// natalius_rr_arb2
// Two-way round-robin selector, purely combinational.
// Ports:
//   req   [1:0]  request vector, bit 0 = CPU, bit 1 = management
//   last         last granted requester ID
//   grant [1:0]  one-hot grant (all zero when no request)
module natalius_rr_arb2
    import natalius_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        // On contention, the requester that did not win last time goes first.
        if (req == 2'b11) begin
            grant = (last == REQ_MGMT) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/natalius_io_arbiter.sv
// natalius_io_arbiter
// Arbitrates Natalius CPU and management writes onto mprj_io[7:0] and
// guarantees each written value stays on the pins for a minimum time.
// Ports:
//   wb_clk_i, wb_rst_i         clock, async active-high reset
//   oe_en_i                    output-enable request (registered twice to io_oeb)
//   cpu_req_i/cpu_data_i       CPU write request and data, cpu_ack_o accept pulse
//   mgmt_req_i/mgmt_data_i     management write request and data, mgmt_ack_o pulse
//   io_out, io_oeb             pad value and active-low output enables
//   busy_o                     FSM not in IDLE
//   grant_id_o                 last granted requester (0 = CPU, 1 = management)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for a request; winner's data is loaded on exit
// ST_LATCH | winner's ack is high this cycle; hold counter loaded
// ST_HOLD  | counting down; requests ignored; leaves after counter reads 0
module natalius_io_arbiter
    import natalius_pkg::*;
#(
    parameter int                 HOLD_CYCLES = 4,
    parameter logic [PORT_W-1:0]  RESET_VALUE = 8'h00
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              oe_en_i,
    input  logic              cpu_req_i,
    input  logic [PORT_W-1:0] cpu_data_i,
    output logic              cpu_ack_o,
    input  logic              mgmt_req_i,
    input  logic [PORT_W-1:0] mgmt_data_i,
    output logic              mgmt_ack_o,
    output logic [PORT_W-1:0] io_out,
    output logic [PORT_W-1:0] io_oeb,
    output logic              busy_o,
    output logic              grant_id_o
);

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic        oe_q;
    logic [1:0]  grant;

    natalius_rr_arb2 u_rr (
        .req   ({mgmt_req_i, cpu_req_i}),
        .last  (grant_id_o),
        .grant (grant)
    );

    // Output-enable path is independent of the FSM.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            oe_q   <= 1'b0;
            io_oeb <= '1;
        end else begin
            oe_q   <= oe_en_i;
            io_oeb <= {PORT_W{~oe_q}};
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state      <= ST_IDLE;
            io_out     <= RESET_VALUE;
            cpu_ack_o  <= 1'b0;
            mgmt_ack_o <= 1'b0;
            busy_o     <= 1'b0;
            grant_id_o <= REQ_MGMT;
            cnt        <= 8'd0;
        end else begin
            cpu_ack_o  <= 1'b0;
            mgmt_ack_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|grant) begin
                        // Ack is registered here so it is high during LATCH.
                        state      <= ST_LATCH;
                        busy_o     <= 1'b1;
                        grant_id_o <= grant[REQ_MGMT];
                        io_out     <= grant[REQ_MGMT] ? mgmt_data_i : cpu_data_i;
                        cpu_ack_o  <= grant[REQ_CPU];
                        mgmt_ack_o <= grant[REQ_MGMT];
                    end
                end
                ST_LATCH: begin
                    cnt   <= HOLD_LOAD;
                    state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (cnt == 8'd0) begin
                        state  <= ST_IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
